// File: rtl/core_boot_seq.sv
// core_boot_seq: core start-up / shut-down sequencer.
//   Holds the core in reset after a start request, releases it, waits a
//   settle delay (doubled when sram_dly_i=1), then raises fetch enable.
//   On fetch-enable withdrawal it drains the core until idle (bounded by a
//   timeout) and returns it to reset.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   fetch_en_i       start request level
//   sram_dly_i       1 doubles the settle delay (sampled when leaving RST_HOLD)
//   core_idle_i      core has no outstanding transactions
//   core_rst_no      core reset, active-low
//   core_fetch_en_o  core fetch enable
//   running_o        high while in RUN
//   timeout_o        sticky: the last drain timed out
//   boot_cnt_o       completed boots, saturating at 255
module core_boot_seq #(
  parameter int unsigned RstHoldCycles = 16,
  parameter int unsigned FetchDelay    = 8,
  parameter int unsigned DrainTimeout  = 64,
  parameter int unsigned CntWidth      = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       fetch_en_i,
  input  logic       sram_dly_i,
  input  logic       core_idle_i,
  output logic       core_rst_no,
  output logic       core_fetch_en_o,
  output logic       running_o,
  output logic       timeout_o,
  output logic [7:0] boot_cnt_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_HOLD = 3'd1,
    RELEASE  = 3'd2,
    RUN      = 3'd3,
    DRAIN    = 3'd4
  } state_t;

  state_t              r_state;
  logic [CntWidth-1:0] r_cnt;
  logic                r_core_rst_n;
  logic                r_fetch_en;
  logic                r_running;
  logic                r_timeout;
  logic [7:0]          r_boot_cnt;

  state_t              w_state_n;
  logic [CntWidth-1:0] w_cnt_n;
  logic                w_core_rst_n_n;
  logic                w_fetch_en_n;
  logic                w_running_n;
  logic                w_timeout_n;
  logic [7:0]          w_boot_cnt_n;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_core_rst_n <= 1'b0;
      r_fetch_en   <= 1'b0;
      r_running    <= 1'b0;
      r_timeout    <= 1'b0;
      r_boot_cnt   <= '0;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_core_rst_n <= w_core_rst_n_n;
      r_fetch_en   <= w_fetch_en_n;
      r_running    <= w_running_n;
      r_timeout    <= w_timeout_n;
      r_boot_cnt   <= w_boot_cnt_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_timeout_n  = r_timeout;
    w_boot_cnt_n = r_boot_cnt;

    case (r_state)
      IDLE: begin
        if (fetch_en_i) begin
          w_state_n   = RST_HOLD;
          w_cnt_n     = CntWidth'(RstHoldCycles - 1);
          w_timeout_n = 1'b0;
        end
      end
      RST_HOLD: begin
        if (!fetch_en_i) begin
          w_state_n = IDLE;
          w_cnt_n   = '0;
        end else if (r_cnt == '0) begin
          w_state_n = RELEASE;
          w_cnt_n   = sram_dly_i ? CntWidth'(2 * FetchDelay - 1)
                                 : CntWidth'(FetchDelay - 1);
        end else begin
          w_cnt_n = r_cnt - CntWidth'(1);
        end
      end
      RELEASE: begin
        if (!fetch_en_i) begin
          w_state_n = IDLE;
          w_cnt_n   = '0;
        end else if (r_cnt == '0) begin
          w_state_n    = RUN;
          w_boot_cnt_n = (r_boot_cnt == 8'hFF) ? r_boot_cnt : r_boot_cnt + 8'd1;
        end else begin
          w_cnt_n = r_cnt - CntWidth'(1);
        end
      end
      RUN: begin
        if (!fetch_en_i) begin
          w_state_n = DRAIN;
          w_cnt_n   = CntWidth'(DrainTimeout - 1);
        end
      end
      DRAIN: begin
        // idle wins over the timeout; fetch_en_i is not looked at here
        if (core_idle_i) begin
          w_state_n = IDLE;
          w_cnt_n   = '0;
        end else if (r_cnt == '0) begin
          w_state_n   = IDLE;
          w_timeout_n = 1'b1;
        end else begin
          w_cnt_n = r_cnt - CntWidth'(1);
        end
      end
      default: begin
        w_state_n = IDLE;
        w_cnt_n   = '0;
      end
    endcase

    // outputs registered from the next state so they move with the state
    w_core_rst_n_n = (w_state_n == RELEASE) || (w_state_n == RUN) || (w_state_n == DRAIN);
    w_fetch_en_n   = (w_state_n == RUN);
    w_running_n    = (w_state_n == RUN);
  end

  assign core_rst_no     = r_core_rst_n;
  assign core_fetch_en_o = r_fetch_en;
  assign running_o       = r_running;
  assign timeout_o       = r_timeout;
  assign boot_cnt_o      = r_boot_cnt;

endmodule

// File: tb/tb_core_boot_seq.sv
module tb_core_boot_seq;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       fetch_en_i;
  logic       sram_dly_i;
  logic       core_idle_i;
  logic       core_rst_no;
  logic       core_fetch_en_o;
  logic       running_o;
  logic       timeout_o;
  logic [7:0] boot_cnt_o;

  int errors = 0;
  int checks = 0;

  core_boot_seq #(
    .RstHoldCycles(16),
    .FetchDelay   (8),
    .DrainTimeout (64),
    .CntWidth     (8)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .fetch_en_i     (fetch_en_i),
    .sram_dly_i     (sram_dly_i),
    .core_idle_i    (core_idle_i),
    .core_rst_no    (core_rst_no),
    .core_fetch_en_o(core_fetch_en_o),
    .running_o      (running_o),
    .timeout_o      (timeout_o),
    .boot_cnt_o     (boot_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // one active edge, then sample 1 time unit later
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // fetch_en rises before edge 0; returns just after the edge that enters RUN
  task automatic boot(input logic sram);
    fetch_en_i = 1'b1;
    sram_dly_i = sram;
    repeat (sram ? 33 : 25) tick();
  endtask

  // leave RUN with the core already idle: RUN -> DRAIN -> IDLE
  task automatic drain_idle();
    fetch_en_i  = 1'b0;
    core_idle_i = 1'b1;
    tick();
    tick();
    core_idle_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; fetch_en_i = 1'b0; sram_dly_i = 1'b0; core_idle_i = 1'b0;
    #2;
    checks++; if (core_rst_no !== 1'b0) begin errors++; $display("FAIL reset_rst_n: got %b want 0", core_rst_no); end
    checks++; if (core_fetch_en_o !== 1'b0) begin errors++; $display("FAIL reset_fetch: got %b want 0", core_fetch_en_o); end
    checks++; if (running_o !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
    checks++; if (boot_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_boot_cnt: got %0d want 0", boot_cnt_o); end
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
    checks++; if (core_rst_no !== 1'b0) begin errors++; $display("FAIL idle_rst_n: got %b want 0", core_rst_no); end
  endtask

  task automatic test_boot_normal();
    fetch_en_i = 1'b1;
    sram_dly_i = 1'b0;
    for (int i = 0; i <= 24; i++) begin
      tick();
      if (i == 15) begin
        checks++; if (core_rst_no !== 1'b0) begin errors++; $display("FAIL t1_rst_n_e15: got %b want 0", core_rst_no); end
      end
      if (i == 16) begin
        checks++; if (core_rst_no !== 1'b1) begin errors++; $display("FAIL t1_rst_n_e16: got %b want 1", core_rst_no); end
      end
      if (i == 23) begin
        checks++; if (core_fetch_en_o !== 1'b0) begin errors++; $display("FAIL t1_fetch_e23: got %b want 0", core_fetch_en_o); end
      end
    end
    checks++; if (core_fetch_en_o !== 1'b1) begin errors++; $display("FAIL t1_fetch_e24: got %b want 1", core_fetch_en_o); end
    checks++; if (running_o !== 1'b1) begin errors++; $display("FAIL t1_running_e24: got %b want 1", running_o); end
    checks++; if (boot_cnt_o !== 8'd1) begin errors++; $display("FAIL t1_boot_cnt: got %0d want 1", boot_cnt_o); end
    drain_idle();
  endtask

  task automatic test_boot_sram_dly();
    fetch_en_i = 1'b1;
    sram_dly_i = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      tick();
      if (i == 20) sram_dly_i = 1'b0;  // toggled inside RELEASE, must not matter
      if (i == 24) begin
        checks++; if (core_fetch_en_o !== 1'b0) begin errors++; $display("FAIL t2_fetch_e24: got %b want 0", core_fetch_en_o); end
      end
      if (i == 31) begin
        checks++; if (core_fetch_en_o !== 1'b0) begin errors++; $display("FAIL t2_fetch_e31: got %b want 0", core_fetch_en_o); end
      end
    end
    checks++; if (core_fetch_en_o !== 1'b1) begin errors++; $display("FAIL t2_fetch_e32: got %b want 1", core_fetch_en_o); end
    checks++; if (boot_cnt_o !== 8'd2) begin errors++; $display("FAIL t2_boot_cnt: got %0d want 2", boot_cnt_o); end
    drain_idle();
  endtask

  task automatic test_abort();
    logic seen_fetch;
    // abort in RST_HOLD
    fetch_en_i = 1'b1;
    sram_dly_i = 1'b0;
    repeat (10) tick();  // edges 0..9
    fetch_en_i = 1'b0;
    tick();              // edge 10
    checks++; if (core_rst_no !== 1'b0) begin errors++; $display("FAIL t3_hold_rst_n: got %b want 0", core_rst_no); end
    tick();
    // abort in RELEASE
    seen_fetch = 1'b0;
    fetch_en_i = 1'b1;
    for (int i = 0; i <= 19; i++) begin
      tick();
      if (core_fetch_en_o) seen_fetch = 1'b1;
    end
    checks++; if (core_rst_no !== 1'b1) begin errors++; $display("FAIL t3_rel_rst_n_e19: got %b want 1", core_rst_no); end
    fetch_en_i = 1'b0;
    tick();              // edge 20
    if (core_fetch_en_o) seen_fetch = 1'b1;
    checks++; if (core_rst_no !== 1'b0) begin errors++; $display("FAIL t3_rel_rst_n_e20: got %b want 0", core_rst_no); end
    checks++; if (seen_fetch !== 1'b0) begin errors++; $display("FAIL t3_fetch_seen: got %b want 0", seen_fetch); end
    checks++; if (boot_cnt_o !== 8'd2) begin errors++; $display("FAIL t3_boot_cnt: got %0d want 2", boot_cnt_o); end
    tick();
  endtask

  task automatic test_drain_idle();
    boot(1'b0);
    checks++; if (boot_cnt_o !== 8'd3) begin errors++; $display("FAIL t4_boot_cnt: got %0d want 3", boot_cnt_o); end
    fetch_en_i = 1'b0;
    tick();  // edge N
    checks++; if (core_fetch_en_o !== 1'b0) begin errors++; $display("FAIL t4_fetch_N: got %b want 0", core_fetch_en_o); end
    checks++; if (running_o !== 1'b0) begin errors++; $display("FAIL t4_running_N: got %b want 0", running_o); end
    checks++; if (core_rst_no !== 1'b1) begin errors++; $display("FAIL t4_rst_n_N: got %b want 1", core_rst_no); end
    tick();  // N+1
    fetch_en_i = 1'b1;  // re-asserted during DRAIN
    repeat (3) tick();  // N+2..N+4
    checks++; if (core_rst_no !== 1'b1) begin errors++; $display("FAIL t4_rst_n_N4: got %b want 1", core_rst_no); end
    core_idle_i = 1'b1;
    tick();  // N+5
    core_idle_i = 1'b0;
    checks++; if (core_rst_no !== 1'b0) begin errors++; $display("FAIL t4_rst_n_N5: got %b want 0", core_rst_no); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL t4_timeout: got %b want 0", timeout_o); end
    // restart from IDLE at N+6, so reset releases after N+22
    repeat (16) tick();  // N+6..N+21
    checks++; if (core_rst_no !== 1'b0) begin errors++; $display("FAIL t4_restart_N21: got %b want 0", core_rst_no); end
    tick();  // N+22
    checks++; if (core_rst_no !== 1'b1) begin errors++; $display("FAIL t4_restart_N22: got %b want 1", core_rst_no); end
    fetch_en_i = 1'b0;
    tick();
  endtask

  task automatic test_drain_timeout();
    boot(1'b0);
    fetch_en_i  = 1'b0;
    core_idle_i = 1'b0;
    tick();              // enter DRAIN
    repeat (63) tick();
    checks++; if (core_rst_no !== 1'b1) begin errors++; $display("FAIL t5_rst_n_63: got %b want 1", core_rst_no); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL t5_timeout_63: got %b want 0", timeout_o); end
    tick();              // 64th DRAIN edge
    checks++; if (core_rst_no !== 1'b0) begin errors++; $display("FAIL t5_rst_n_64: got %b want 0", core_rst_no); end
    checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL t5_timeout_64: got %b want 1", timeout_o); end
    tick();
    checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL t5_timeout_sticky: got %b want 1", timeout_o); end
    fetch_en_i = 1'b1;
    tick();              // RST_HOLD entry
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL t5_timeout_clear: got %b want 0", timeout_o); end
    fetch_en_i = 1'b0;
    tick();
  endtask

  task automatic test_saturate_async_reset();
    int exp_cnt;
    exp_cnt = 4;
    for (int k = 1; k <= 256; k++) begin
      boot(1'b0);
      exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      if (k == 250 || k == 251 || k == 256) begin
        checks++; if (boot_cnt_o !== 8'(exp_cnt)) begin errors++; $display("FAIL t6_boot_cnt_k%0d: got %0d want %0d", k, boot_cnt_o, exp_cnt); end
      end
      if (k != 256) drain_idle();
    end
    checks++; if (running_o !== 1'b1) begin errors++; $display("FAIL t6_running: got %b want 1", running_o); end
    #3;
    rst_i = 1'b1;        // mid-cycle, no clock edge before the checks
    #1;
    checks++; if (core_rst_no !== 1'b0) begin errors++; $display("FAIL t6_rst_n: got %b want 0", core_rst_no); end
    checks++; if (core_fetch_en_o !== 1'b0) begin errors++; $display("FAIL t6_fetch: got %b want 0", core_fetch_en_o); end
    checks++; if (running_o !== 1'b0) begin errors++; $display("FAIL t6_running_rst: got %b want 0", running_o); end
    checks++; if (boot_cnt_o !== 8'd0) begin errors++; $display("FAIL t6_boot_cnt_rst: got %0d want 0", boot_cnt_o); end
    fetch_en_i = 1'b0;
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_boot_normal();
    test_boot_sram_dly();
    test_abort();
    test_drain_idle();
    test_drain_timeout();
    test_saturate_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_boot_seq.md
Name: core_boot_seq

Overview:
- Sits directly downstream of the SoC control register block and consumes its fetch-enable and SRAM-delay outputs.
- Sequences the core start-up: holds the core in reset, releases it, waits a settle delay, then raises the core fetch enable.
- On fetch-enable withdrawal, drains the core until it is idle, bounded by a timeout, and returns it to reset.

Parameters:
- RstHoldCycles, 16: cycles the core reset is held after a start request; must be >= 1.
- FetchDelay, 8: cycles from reset release to fetch enable; doubled when sram_dly_i=1; must be >= 1.
- DrainTimeout, 64: maximum cycles spent in DRAIN before forcing reset; must be >= 1.
- CntWidth, 8: down-counter width; must hold max(RstHoldCycles, 2*FetchDelay, DrainTimeout)-1.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- fetch_en_i  in  1  start request level, from the SoC control fetch-enable register
- sram_dly_i  in  1  from the SoC control SRAM-delay register; 1 doubles the settle delay
- core_idle_i  in  1  core reports no outstanding transactions
- core_rst_no  out  1  core reset, active-low
- core_fetch_en_o  out  1  core fetch enable
- running_o  out  1  high while in RUN
- timeout_o  out  1  sticky: the last drain timed out
- boot_cnt_o  out  8  number of completed boots, saturating

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- All outputs are registered and are derived from the next state, so they change on the same edge as the state.
- Reset takes effect immediately, with no clock edge needed:
  - state=IDLE, counter=0
  - core_rst_no=0, core_fetch_en_o=0, running_o=0, timeout_o=0, boot_cnt_o=0
- States and transitions:
  - IDLE: core_rst_no=0, core_fetch_en_o=0. When fetch_en_i=1 is sampled at edge E0, go to RST_HOLD and load counter=RstHoldCycles-1. timeout_o clears on this entry.
  - RST_HOLD: core_rst_no=0.
    - If fetch_en_i=0, go to IDLE (abort).
    - Else if counter=0, go to RELEASE: core_rst_no=1, counter=FetchDelay-1, or 2*FetchDelay-1 if sram_dly_i=1 at this edge. sram_dly_i is sampled only here.
    - Else decrement the counter.
  - RELEASE: core_rst_no=1, core_fetch_en_o=0.
    - If fetch_en_i=0, go to IDLE: core_rst_no=0 on the next edge.
    - Else if counter=0, go to RUN: core_fetch_en_o=1, running_o=1, boot_cnt_o+=1, saturating at 255.
    - Else decrement the counter.
  - RUN: all outputs hold. If fetch_en_i=0, go to DRAIN: core_fetch_en_o=0, running_o=0, core_rst_no stays 1, counter=DrainTimeout-1.
  - DRAIN:
    - If core_idle_i=1, go to IDLE with core_rst_no=0; takes priority over the timeout.
    - Else if counter=0, go to IDLE with timeout_o=1.
    - Else decrement the counter.
    - fetch_en_i is ignored in DRAIN; a re-assertion is acted on from IDLE one edge later.
- Latency, fetch_en_i first sampled high at edge E0:
  - core_rst_no rises after edge E0+RstHoldCycles.
  - core_fetch_en_o rises after edge E0+RstHoldCycles+FetchDelay, or +2*FetchDelay when sram_dly_i=1.
- Edge cases:
  - A fetch_en_i pulse of one cycle enters RST_HOLD, then aborts to IDLE on the next edge.
  - The counter never wraps: it is only decremented when nonzero.
  - boot_cnt_o does not increment on an abort.
  - Illegal state encodings recover to IDLE.

Test Plan:
1. Defaults, sram_dly_i=0, fetch_en_i rises before edge 0 and stays high -> core_rst_no=1 after edge 16; core_fetch_en_o=1 and running_o=1 after edge 24; boot_cnt_o=1.
2. Same with sram_dly_i=1 -> core_fetch_en_o=1 after edge 32; toggling sram_dly_i during RELEASE has no effect.
3. fetch_en_i dropped before edge 10 (RST_HOLD), and separately before edge 20 (RELEASE) -> IDLE next edge; core_rst_no=0; core_fetch_en_o never asserted; boot_cnt_o unchanged.
4. In RUN, fetch_en_i drops at edge N; core_idle_i rises 5 cycles later -> core_fetch_en_o=0 after edge N; core_rst_no=0 after edge N+5 (first edge sampling core_idle_i=1); timeout_o=0. Re-asserting fetch_en_i during DRAIN restarts only from IDLE.
5. In RUN, fetch_en_i drops and core_idle_i is held at 0 -> IDLE after 64 DRAIN edges; timeout_o=1; timeout_o returns to 0 on the next RST_HOLD entry.
6. Run 256 boot cycles, then assert rst_i asynchronously mid-RUN -> boot_cnt_o reads 255 before reset; all outputs go to 0 without a clock edge.
